qsm_regs_multi: RTL and testbench



---
 rtl/qsm_regs_multi.sv | 219 +++++++++++++++++++++
 tb/tb_qsm_regs_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/qsm_regs_multi.sv
`default_nettype none
// qsm_regs_multi: N-channel QSM control/status/event register bank, readout-memory window, aggregated IRQ.
// Revision 1.0
module qsm_regs_multi #(
  parameter int G_NUM_CH = 2,
  parameter int G_MEM_AW = 7,
  parameter int G_MEM_DW = 16,
  parameter int G_RD_LAT = 1,
  localparam int CH_BITS = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1,
  localparam int AW      = G_MEM_AW + CH_BITS + 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [AW-1:0]                wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_stall_o,
  output logic                         wb_err_o,
  output logic                         wb_rty_o,
  output logic [G_NUM_CH-1:0]          ctrl_reset_o,
  output logic [G_NUM_CH-1:0]          ctrl_trig_o,
  output logic [4*G_NUM_CH-1:0]        ctrl_last_reg_adr_o,
  output logic [4*G_NUM_CH-1:0]        ctrl_max_dim_no_o,
  output logic [10*G_NUM_CH-1:0]       ctrl_read_delay_o,
  input  logic [G_NUM_CH-1:0]          sts_busy_i,
  input  logic [G_NUM_CH-1:0]          sts_done_i,
  input  logic [G_NUM_CH-1:0]          sts_err_many_i,
  input  logic [G_NUM_CH-1:0]          sts_err_fb_i,
  input  logic [4*G_NUM_CH-1:0]        sts_dim_count_i,
  output logic [G_MEM_AW-1:0]          mem_addr_o,
  output logic [G_NUM_CH-1:0]          mem_re_o,
  input  logic [G_NUM_CH*G_MEM_DW-1:0] mem_data_i,
  output logic                         irq_o
);

  localparam int         RIW   = G_MEM_AW + CH_BITS;
  localparam logic [2:0] C_LAT = 3'(G_RD_LAT);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MEM = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [CH_BITS-1:0]        ch_q, ch_d;
  logic [G_MEM_AW-1:0]       addr_q, addr_d;
  logic                      ack_q, ack_d;
  logic [31:0]               dat_q, dat_d;
  logic [G_NUM_CH-1:0]       rst_pulse_q, rst_pulse_d, trig_q, trig_d;
  logic [G_NUM_CH-1:0][3:0]  lar_q, lar_d, mdn_q, mdn_d;
  logic [G_NUM_CH-1:0][9:0]  rdl_q, rdl_d;
  logic [G_NUM_CH-1:0][2:0]  evt_q, evt_d, mask_q, mask_d;
  logic [G_NUM_CH-1:0][2:0]  sts1_q, sts1_d, sts2_q, sts2_d;
  logic                      irq_q, irq_d;

  logic                      accept, is_mem, ch_ok, mem_rd_start;
  logic [CH_BITS-1:0]        adr_ch;
  logic [G_MEM_AW-1:0]       adr_word;
  logic [RIW-1:0]            reg_idx;
  logic [31:0]               reg_rdata;
  logic [G_MEM_DW-1:0]       mem_word;
  logic [G_NUM_CH-1:0]       pend;
  logic                      unused_bits;

  assign is_mem       = wb_adr_i[AW-1];
  assign adr_ch       = wb_adr_i[AW-2 -: CH_BITS];
  assign adr_word     = wb_adr_i[G_MEM_AW+1:2];
  assign reg_idx      = wb_adr_i[AW-2:2];
  assign ch_ok        = int'(adr_ch) < G_NUM_CH;
  // Reset gates acceptance so the combinational memory strobe stays low while held in reset.
  assign accept       = rst_n_i & wb_cyc_i & wb_stb_i & ~ack_q & (state_q == ST_IDLE);
  assign mem_rd_start = accept & is_mem & ~wb_we_i & ch_ok;
  assign unused_bits  = ^{wb_adr_i[1:0], wb_dat_i[31:20]};

  always_comb begin
    reg_rdata = '0;
    pend      = '0;
    mem_word  = '0;
    for (int c = 0; c < G_NUM_CH; c++) begin
      pend[c] = |(evt_q[c] & mask_q[c]);
      if (int'(reg_idx) == 4*c)
        reg_rdata = {12'd0, rdl_q[c], mdn_q[c], lar_q[c], 2'b00};
      if (int'(reg_idx) == 4*c + 1)
        reg_rdata = {24'd0, sts_dim_count_i[4*c +: 4], sts_err_fb_i[c], sts_err_many_i[c],
                     sts_done_i[c], sts_busy_i[c]};
      if (int'(reg_idx) == 4*c + 2)
        reg_rdata = {29'd0, evt_q[c]};
      if (int'(reg_idx) == 4*c + 3)
        reg_rdata = {29'd0, mask_q[c]};
      if (int'(ch_q) == c)
        mem_word = mem_data_i[G_MEM_DW*c +: G_MEM_DW];
    end
    if (int'(reg_idx) == 4*G_NUM_CH)
      reg_rdata = {{(32-G_NUM_CH){1'b0}}, pend};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    addr_d      = addr_q;
    ack_d       = 1'b0;
    dat_d       = dat_q;
    rst_pulse_d = '0;
    trig_d      = '0;
    lar_d       = lar_q;
    mdn_d       = mdn_q;
    rdl_d       = rdl_q;
    mask_d      = mask_q;
    evt_d       = evt_q;
    sts2_d      = sts1_q;
    irq_d       = |pend;
    for (int c = 0; c < G_NUM_CH; c++)
      sts1_d[c] = {sts_err_fb_i[c], sts_err_many_i[c], sts_done_i[c]};

    if (mem_rd_start) begin
      state_d = ST_MEM;
      cnt_d   = 3'd1;
      ch_d    = adr_ch;
      addr_d  = adr_word;
    end else if (accept) begin
      ack_d = 1'b1;
      dat_d = (wb_we_i || is_mem) ? 32'd0 : reg_rdata;
      if (wb_we_i && !is_mem) begin
        for (int c = 0; c < G_NUM_CH; c++) begin
          if (int'(reg_idx) == 4*c) begin
            rst_pulse_d[c] = wb_dat_i[0];
            trig_d[c]      = wb_dat_i[1];
            lar_d[c]       = wb_dat_i[5:2];
            mdn_d[c]       = wb_dat_i[9:6];
            rdl_d[c]       = wb_dat_i[19:10];
          end
          if (int'(reg_idx) == 4*c + 2)
            evt_d[c] = evt_q[c] & ~wb_dat_i[2:0];
          if (int'(reg_idx) == 4*c + 3)
            mask_d[c] = wb_dat_i[2:0];
        end
      end
    end

    // cnt_q counts cycles since the strobe; data is sampled when it reaches the SRAM latency.
    if (state_q == ST_MEM) begin
      if (cnt_q == C_LAT) begin
        state_d                = ST_IDLE;
        cnt_d                  = '0;
        ack_d                  = wb_cyc_i;
        dat_d                  = '0;
        dat_d[G_MEM_DW-1:0]    = mem_word;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end

    // Applied after any W1C so a simultaneous set takes priority.
    for (int c = 0; c < G_NUM_CH; c++)
      evt_d[c] = evt_d[c] | (sts1_q[c] & ~sts2_q[c]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      addr_q      <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      rst_pulse_q <= '0;
      trig_q      <= '0;
      lar_q       <= '0;
      mdn_q       <= '0;
      rdl_q       <= '0;
      evt_q       <= '0;
      mask_q      <= '0;
      sts1_q      <= '0;
      sts2_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      rst_pulse_q <= rst_pulse_d;
      trig_q      <= trig_d;
      lar_q       <= lar_d;
      mdn_q       <= mdn_d;
      rdl_q       <= rdl_d;
      evt_q       <= evt_d;
      mask_q      <= mask_d;
      sts1_q      <= sts1_d;
      sts2_q      <= sts2_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    mem_re_o = '0;
    for (int c = 0; c < G_NUM_CH; c++)
      mem_re_o[c] = mem_rd_start && (int'(adr_ch) == c);
  end

  assign mem_addr_o          = mem_rd_start ? adr_word : addr_q;
  assign wb_dat_o            = dat_q;
  assign wb_ack_o            = ack_q;
  assign wb_stall_o          = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_err_o            = 1'b0;
  assign wb_rty_o            = 1'b0;
  assign ctrl_reset_o        = rst_pulse_q;
  assign ctrl_trig_o         = trig_q;
  assign ctrl_last_reg_adr_o = lar_q;
  assign ctrl_max_dim_no_o   = mdn_q;
  assign ctrl_read_delay_o   = rdl_q;
  assign irq_o               = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_qsm_regs_multi.sv
`default_nettype none
// tb_qsm_regs_multi: directed bench for qsm_regs_multi with 4 channels and a 3-cycle SRAM latency.
// Revision 1.0
module tb_qsm_regs_multi;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [11:0] wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o, wb_stall_o, wb_err_o, wb_rty_o;
  logic [3:0]  ctrl_reset_o, ctrl_trig_o;
  logic [15:0] ctrl_last_reg_adr_o, ctrl_max_dim_no_o;
  logic [39:0] ctrl_read_delay_o;
  logic [3:0]  sts_busy_i, sts_done_i, sts_err_many_i, sts_err_fb_i;
  logic [15:0] sts_dim_count_i;
  logic [6:0]  mem_addr_o;
  logic [3:0]  mem_re_o;
  logic [63:0] mem_data_i;
  logic        irq_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  qsm_regs_multi #(.G_NUM_CH(4), .G_MEM_AW(7), .G_MEM_DW(16), .G_RD_LAT(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .ctrl_reset_o(ctrl_reset_o), .ctrl_trig_o(ctrl_trig_o),
    .ctrl_last_reg_adr_o(ctrl_last_reg_adr_o), .ctrl_max_dim_no_o(ctrl_max_dim_no_o),
    .ctrl_read_delay_o(ctrl_read_delay_o),
    .sts_busy_i(sts_busy_i), .sts_done_i(sts_done_i), .sts_err_many_i(sts_err_many_i),
    .sts_err_fb_i(sts_err_fb_i), .sts_dim_count_i(sts_dim_count_i),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_data_i(mem_data_i),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one access at the current cycle, returns in the ack cycle with the latency in cycles.
  task automatic wb_xfer(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                         input logic [31:0] exp, input string tag, output int lat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    if (!we) sb.push_back(exp);
    lat = 0;
    do begin
      idle();
      lat++;
    end while (!wb_ack_o && lat < 16);
    if (!wb_ack_o) begin
      chk({tag, "_ack"}, {63'd0, wb_ack_o}, 64'd1);
      if (!we) void'(sb.pop_front());
    end else if (!we) begin
      chk(tag, {32'd0, wb_dat_o}, {32'd0, sb.pop_front()});
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  initial begin
    int lat;
    int k;
    int acks;
    logic got;

    rst_n_i = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0;
    sts_busy_i = '0; sts_done_i = '0; sts_err_many_i = '0; sts_err_fb_i = '0;
    sts_dim_count_i = '0;
    mem_data_i = {16'hDEAD, 16'h3333, 16'h2222, 16'h1111};
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", {63'd0, wb_ack_o}, 64'd0);
    chk("rst_dat", {32'd0, wb_dat_o}, 64'd0);
    chk("rst_pulse", {56'd0, ctrl_reset_o, ctrl_trig_o}, 64'd0);
    chk("rst_lar", {48'd0, ctrl_last_reg_adr_o}, 64'd0);
    chk("rst_mdn", {48'd0, ctrl_max_dim_no_o}, 64'd0);
    chk("rst_rdl", {24'd0, ctrl_read_delay_o}, 64'd0);
    chk("rst_mem", {53'd0, mem_re_o, mem_addr_o}, 64'd0);
    chk("rst_irq", {61'd0, irq_o, wb_err_o, wb_rty_o}, 64'd0);
    rst_n_i = 1'b1;
    idle();

    for (int c = 0; c < 4; c++) begin
      wb_xfer(1'b0, 12'(16*c + 0), 32'd0, 32'd0, "rst_ctrl_rd", lat); idle();
      wb_xfer(1'b0, 12'(16*c + 8), 32'd0, 32'd0, "rst_evt_rd", lat); idle();
      wb_xfer(1'b0, 12'(16*c + 12), 32'd0, 32'd0, "rst_mask_rd", lat); idle();
    end

    // CONTROL of channel 2 with every field bit set
    wb_xfer(1'b1, 12'h020, 32'h000F_FFFF, 32'd0, "ctrl2_wr", lat);
    chk("ctrl2_wr_lat", 64'(lat), 64'd1);
    chk("ctrl2_reset_pulse", {60'd0, ctrl_reset_o}, 64'h4);
    chk("ctrl2_trig_pulse", {60'd0, ctrl_trig_o}, 64'h4);
    chk("ctrl2_lar", {48'd0, ctrl_last_reg_adr_o}, 64'h0F00);
    chk("ctrl2_mdn", {48'd0, ctrl_max_dim_no_o}, 64'h0F00);
    chk("ctrl2_rdl", {24'd0, ctrl_read_delay_o}, 64'h3FF0_0000);
    idle();
    chk("ctrl2_pulse_end", {56'd0, ctrl_reset_o, ctrl_trig_o}, 64'd0);
    wb_xfer(1'b0, 12'h020, 32'd0, 32'h000F_FFFC, "ctrl2_rd", lat); idle();
    wb_xfer(1'b0, 12'h000, 32'd0, 32'd0, "ctrl0_rd", lat); idle();
    wb_xfer(1'b0, 12'h010, 32'd0, 32'd0, "ctrl1_rd", lat); idle();
    wb_xfer(1'b0, 12'h030, 32'd0, 32'd0, "ctrl3_rd", lat); idle();

    // Live status of channel 3
    sts_busy_i = 4'b1000;
    sts_dim_count_i = 16'hA000;
    wb_xfer(1'b0, 12'h034, 32'd0, 32'h0000_00A1, "sts3_rd", lat); idle();
    sts_busy_i = '0;
    sts_dim_count_i = '0;

    // err_fb pulse on channel 1 with its mask bit set
    wb_xfer(1'b1, 12'h01C, 32'h4, 32'd0, "mask1_wr", lat); idle();
    sts_err_fb_i[1] = 1'b1;
    idle();
    sts_err_fb_i[1] = 1'b0;
    chk("irq_t1", {63'd0, irq_o}, 64'd0);
    idle();
    chk("irq_t2", {63'd0, irq_o}, 64'd0);
    idle();
    chk("irq_t3", {63'd0, irq_o}, 64'd1);
    wb_xfer(1'b0, 12'h018, 32'd0, 32'h4, "evt1_rd", lat); idle();
    wb_xfer(1'b0, 12'h040, 32'd0, 32'h2, "pend_rd", lat); idle();
    wb_xfer(1'b1, 12'h018, 32'h4, 32'd0, "evt1_clr", lat);
    chk("irq_hold_at_ack", {63'd0, irq_o}, 64'd1);
    idle();
    chk("irq_fall", {63'd0, irq_o}, 64'd0);
    wb_xfer(1'b0, 12'h018, 32'd0, 32'h0, "evt1_rd_clr", lat); idle();

    // done edge on channel 0 coinciding with a W1C of the same bit
    sts_done_i[0] = 1'b1;
    idle();
    wb_xfer(1'b1, 12'h008, 32'h1, 32'd0, "evt0_clr_race", lat); idle();
    wb_xfer(1'b0, 12'h008, 32'd0, 32'h1, "evt0_set_wins", lat); idle();
    wb_xfer(1'b1, 12'h008, 32'h1, 32'd0, "evt0_clr", lat); idle();
    wb_xfer(1'b0, 12'h008, 32'd0, 32'h0, "evt0_cleared", lat); idle();
    sts_done_i[0] = 1'b0;

    // Unmapped register word
    wb_xfer(1'b1, 12'h044, 32'hFFFF_FFFF, 32'd0, "unmapped_wr", lat); idle();
    wb_xfer(1'b0, 12'h044, 32'd0, 32'h0, "unmapped_rd", lat); idle();

    // Memory read of channel 3, word 5; SRAM data valid only in cycle T+3
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'hE14;
    sb.push_back(32'h0000_BEEF);
    #1;
    chk("mem_re", {60'd0, mem_re_o}, 64'h8);
    chk("mem_addr", {57'd0, mem_addr_o}, 64'h05);
    k = 0;
    got = 1'b0;
    while (!got && k < 16) begin
      idle();
      k++;
      mem_data_i[63:48] = (k == 3) ? 16'hBEEF : 16'hDEAD;
      if (k == 1) chk("mem_re_single", {60'd0, mem_re_o}, 64'h0);
      if (k == 2) chk("mem_addr_hold", {57'd0, mem_addr_o}, 64'h05);
      got = wb_ack_o;
    end
    chk("mem_lat", 64'(k), 64'd4);
    chk("mem_dat", {32'd0, wb_dat_o}, {32'd0, sb.pop_front()});
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    idle();

    // Reset while waiting on the SRAM
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h804;
    sb.push_back(32'h0000_1111);
    idle();
    rst_n_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    sb.delete();
    idle();
    idle();
    rst_n_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (wb_ack_o) acks++;
    end
    chk("no_ack_after_rst", 64'(acks), 64'd0);
    wb_xfer(1'b0, 12'h020, 32'd0, 32'h0, "post_rst_rd", lat);
    chk("post_rst_rd_lat", 64'(lat), 64'd1);
    idle();
    wb_xfer(1'b1, 12'h010, 32'h0000_0157, 32'd0, "post_rst_wr", lat); idle();
    wb_xfer(1'b0, 12'h010, 32'd0, 32'h0000_0154, "post_rst_ctrl1", lat);
    chk("post_rst_ctrl1_lat", 64'(lat), 64'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
